fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the UM-32 core. Holds the execution finger (PC), reads the next platter from array 0 through `mem_sys`, and presents it to `instr_decoder` and `control_unit` with a valid/ack handshake. On completion the control unit returns jump (load-program) or halt information. The stage sits directly upstream of the control unit's operator FSMs.

## Interface
Parameters:
- `MEM_RD_LAT`, 1: cycles from the edge that samples a read request in `mem_sys` to the edge at which `mem_out` is captured (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `enable`  in  1  permits starting new fetches.
- `array0_len`  in  32  current platter count of array 0.
- `mem_out`  in  32  `mem_sys` read data.
- `instr_ack`  in  1  control unit has finished the presented instruction.
- `jump`  in  1  qualifies `jump_target`; sampled only with `instr_ack`.
- `jump_target`  in  32  new finger (load-program, C register value).
- `halt`  in  1  halt operator executed; sampled only with `instr_ack`.
- `mem_in`  out  `mem_in_bus_t`  request to `mem_sys` (through `mem_in_bus_buf`).
- `instr_word`  out  32  latched instruction.
- `instr_valid`  out  1  `instr_word` is valid.
- `pc`  out  32  finger of the next platter to fetch.
- `halted`  out  1  sticky halt.
- `fault`  out  1  sticky fetch fault (finger out of range).

## Operation
- States: IDLE, REQ, WAIT, VALID, HALT, FAULT. Reset → IDLE.
- Reset values: `pc`=0, `instr_word`=0, `instr_valid`=0, `halted`=0, `fault`=0, `mem_in`={mode=MEM_MODE_READ, address=0, offset=0, data=0}.
- `mem_in.mode` is always MEM_MODE_READ (2'b00). The block never writes. `address` is always 0 (array 0). `data` is always 0.
- IDLE: `enable`=1 → REQ; otherwise stay.
- REQ: if `pc` ≥ `array0_len` (unsigned), go to FAULT and issue no request. Otherwise drive `offset`=`pc`, load the wait counter with `MEM_RD_LAT`, and go to WAIT.
- WAIT: `offset` stays held at `pc`. Decrement the counter. When it expires, capture `mem_out` into `instr_word`, set `pc` ← `pc`+1 (mod 2^32, wraps 0xFFFFFFFF→0), and go to VALID.
- VALID: `instr_valid`=1. `instr_word` is held stable until ack. On `instr_ack`:
  - `halt`=1 → HALT. `halt` wins over a simultaneous `jump`.
  - else `jump`=1 → `pc` ← `jump_target`.
  - then go to REQ if `enable`=1, else IDLE.
- HALT: `halted`=1, no requests. Exit only by reset.
- FAULT: `fault`=1, `instr_valid`=0, no requests. Exit only by reset.
- `enable` low during REQ/WAIT: the read in flight completes and the instruction is presented. Only new fetches are blocked.
- `instr_ack` outside VALID is ignored.
- Reset asserted mid-WAIT: all state returns to reset values immediately. Any late `mem_out` data is discarded.

## Timing
- With `enable` sampled high in IDLE at edge E0: REQ during E0→E1, WAIT for `MEM_RD_LAT` cycles, `instr_valid` high after edge E0+1+`MEM_RD_LAT`.
- `instr_ack` sampled at edge A0: `instr_valid` low after A0. Next `instr_valid` high after A0+1+`MEM_RD_LAT`.
- Throughput: one instruction per (2+`MEM_RD_LAT`) cycles minimum, given ack in the first VALID cycle.
- The `pc` update is visible one cycle after the capture/ack edge.
- `halted` and `fault` assert one cycle after entering their state and are never deasserted except by reset.

## Structure
- `BusTypes` gains:
  - `fetch_state_t` enum (6 states);
  - constant `MEM_MODE_READ` = 2'b00;
  - constant `MEM_MODE_WRITE` = 2'b01.
- Reuses `mem_in_bus_t`.
- Single module `fetch_unit`. No sub-module. The wait counter is `$clog2(MEM_RD_LAT+1)` bits, inline.
- `instr_word` feeds the existing `instr_decoder` unchanged.

## Test plan
- Preload array 0 [0..2] = 0x30000053, 0x40000053, 0x70000000, with `array0_len`=3 and `enable`=1. Expect three VALIDs with those words; `pc` = 1, 2, 3; requests issued at offsets 0, 1, 2.
- Ack the word at offset 0 with `jump`=1, `jump_target`=2. Expect the next `mem_in.offset`=2 and `instr_word`=0x70000000.
- Ack with `halt`=1 and `jump`=1. Expect `halted`=1, no further requests, and `pc` unchanged.
- Set `array0_len`=1 and ack the first word. Expect FAULT, `fault`=1, `instr_valid`=0, and no request at offset 1.
- Assert `reset` low during WAIT. Expect `pc`=0, `instr_valid`=0, `instr_word`=0 asynchronously. After release with `enable`=1, expect a refetch from offset 0.
- Pulse `enable` low during REQ. Expect the current word to still be presented; after ack, expect IDLE with no request until `enable` returns. Repeat with `MEM_RD_LAT`=3 and check valid latency is 4 edges.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the UM-32 fetch stage: memory request bus, memory modes
// and the fetch FSM state encoding.
package fetch_unit_pkg;

   localparam logic [1:0] MEM_MODE_READ  = 2'b00;
   localparam logic [1:0] MEM_MODE_WRITE = 2'b01;

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] address;
      logic [31:0] offset;
      logic [31:0] data;
   } mem_in_bus_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_VALID,
      ST_HALT,
      ST_FAULT
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// UM-32 instruction fetch: reads platters from array 0 at the finger and
// presents them to the control unit with a valid/ack handshake.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] array0_len,
   input  logic [31:0] mem_out,
   input  logic        instr_ack,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        halt,
   output mem_in_bus_t mem_in,
   output logic [31:0] instr_word,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic        halted,
   output logic        fault
);

   localparam int               CNT_W    = $clog2(MEM_RD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LAT);

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      off_q, off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_now;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         word_q  <= '0;
         off_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      word_d  = word_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      req_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (pc_q >= array0_len) begin
               state_d = ST_FAULT;
            end else begin
               req_now = 1'b1;
               off_d   = pc_q;
               cnt_d   = CNT_LOAD;
               state_d = ST_WAIT;
            end
         end
         // Offset register already holds pc here, so the request stays stable.
         ST_WAIT: begin
            if (cnt_q == CNT_ONE) begin
               word_d  = mem_out;
               pc_d    = pc_q + 32'd1;
               state_d = ST_VALID;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_VALID: begin
            if (instr_ack) begin
               if (halt) begin
                  state_d = ST_HALT;
               end else begin
                  if (jump) pc_d = jump_target;
                  state_d = enable ? ST_REQ : ST_IDLE;
               end
            end
         end
         ST_HALT:  state_d = ST_HALT;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The request offset shows pc combinationally in REQ so mem_sys can sample it at the REQ exit edge.
   always_comb begin
      mem_in         = '0;
      mem_in.mode    = MEM_MODE_READ;
      mem_in.address = '0;
      mem_in.data    = '0;
      mem_in.offset  = req_now ? pc_q : off_q;
   end

   assign instr_word  = word_q;
   assign instr_valid = (state_q == ST_VALID);
   assign pc          = pc_q;
   assign halted      = (state_q == ST_HALT);
   assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// program walk checked against a finger-level reference model.
`timescale 1ns/1ps
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        en_a, ack_a, jmp_a, hlt_a;
   logic [31:0] len_a, jt_a, mout_a;
   mem_in_bus_t min_a;
   logic [31:0] word_a, pc_a;
   logic        valid_a, halted_a, fault_a;

   logic        en_b, ack_b, jmp_b, hlt_b;
   logic [31:0] len_b, jt_b, mout_b;
   mem_in_bus_t min_b;
   logic [31:0] word_b, pc_b;
   logic        valid_b, halted_b, fault_b;

   logic [31:0] mem [0:15];
   logic [31:0] pipe_b [0:2];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.MEM_RD_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .array0_len(len_a), .mem_out(mout_a),
      .instr_ack(ack_a), .jump(jmp_a), .jump_target(jt_a), .halt(hlt_a),
      .mem_in(min_a), .instr_word(word_a), .instr_valid(valid_a), .pc(pc_a),
      .halted(halted_a), .fault(fault_a));

   fetch_unit #(.MEM_RD_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .array0_len(len_b), .mem_out(mout_b),
      .instr_ack(ack_b), .jump(jmp_b), .jump_target(jt_b), .halt(hlt_b),
      .mem_in(min_b), .instr_word(word_b), .instr_valid(valid_b), .pc(pc_b),
      .halted(halted_b), .fault(fault_b));

   // mem_sys models: data for the offset sampled at edge E appears for capture at E+LAT
   always @(posedge clk) mout_a <= mem[min_a.offset[3:0]];
   always @(posedge clk) begin
      pipe_b[0] <= mem[min_b.offset[3:0]];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign mout_b = pipe_b[2];

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      en_a = 0; ack_a = 0; jmp_a = 0; hlt_a = 0; jt_a = 0; len_a = 0;
      en_b = 0; ack_b = 0; jmp_b = 0; hlt_b = 0; jt_b = 0; len_b = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1;
   endtask

   task automatic wait_valid_a(input int budget, output int edges);
      edges = 0;
      while (valid_a !== 1'b1 && edges < budget) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic ack_a_pulse(input logic j, input logic [31:0] t, input logic h);
      ack_a = 1; jmp_a = j; jt_a = t; hlt_a = h;
      @(negedge clk);
      ack_a = 0; jmp_a = 0; hlt_a = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0;
      #3;
      checks++; if (pc_a !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_a); end
      checks++; if (word_a !== 32'd0) begin errors++; $display("FAIL reset_word got=%h exp=0", word_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      checks++; if (halted_a !== 1'b0 || fault_a !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", halted_a, fault_a); end
      checks++; if (min_a !== '0) begin errors++; $display("FAIL reset_mem_in got=%h exp=0", min_a); end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_program();
      int e;
      do_reset();
      mem[0] = 32'h30000053; mem[1] = 32'h40000053; mem[2] = 32'h70000000;
      len_a = 3; en_a = 1;
      for (int k = 0; k < 3; k++) begin
         wait_valid_a(20, e);
         checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL prog_valid%0d got=%b exp=1", k, valid_a); end
         checks++; if (word_a !== mem[k]) begin errors++; $display("FAIL prog_word%0d got=%h exp=%h", k, word_a, mem[k]); end
         checks++; if (pc_a !== k + 1) begin errors++; $display("FAIL prog_pc%0d got=%0d exp=%0d", k, pc_a, k + 1); end
         checks++; if (min_a.offset !== k) begin errors++; $display("FAIL prog_off%0d got=%0d exp=%0d", k, min_a.offset, k); end
         ack_a_pulse(0, 0, 0);
      end
      repeat (3) @(negedge clk);
      checks++; if (fault_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL prog_end_fault got=%b/%b exp=1/0", fault_a, valid_a); end
   endtask

   task automatic test_jump();
      int e;
      do_reset();
      len_a = 3; en_a = 1;
      wait_valid_a(20, e);
      checks++; if (word_a !== 32'h30000053) begin errors++; $display("FAIL jump_first got=%h exp=30000053", word_a); end
      ack_a_pulse(1, 32'd2, 0);
      checks++; if (pc_a !== 32'd2 || min_a.offset !== 32'd2) begin errors++; $display("FAIL jump_req got pc=%0d off=%0d exp=2/2", pc_a, min_a.offset); end
      wait_valid_a(20, e);
      checks++; if (word_a !== 32'h70000000 || pc_a !== 32'd3) begin errors++; $display("FAIL jump_word got=%h pc=%0d exp=70000000 pc=3", word_a, pc_a); end
   endtask

   task automatic test_halt();
      int e;
      bit bad;
      do_reset();
      len_a = 3; en_a = 1;
      wait_valid_a(20, e);
      ack_a_pulse(1, 32'd2, 1);
      checks++; if (halted_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL halt_flag got=%b/%b exp=1/0", halted_a, valid_a); end
      checks++; if (pc_a !== 32'd1) begin errors++; $display("FAIL halt_pc got=%0d exp=1", pc_a); end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (min_a.offset !== 32'd0 || valid_a !== 1'b0 || pc_a !== 32'd1 || halted_a !== 1'b1) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL halt_quiet got=activity exp=none"); end
   endtask

   task automatic test_fault();
      int e;
      bit seen1;
      do_reset();
      len_a = 1; en_a = 1;
      wait_valid_a(20, e);
      checks++; if (word_a !== mem[0]) begin errors++; $display("FAIL fault_word got=%h exp=%h", word_a, mem[0]); end
      ack_a_pulse(0, 0, 0);
      seen1 = (min_a.offset === 32'd1);
      repeat (10) begin
         @(negedge clk);
         if (min_a.offset === 32'd1) seen1 = 1;
      end
      checks++; if (fault_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL fault_flag got=%b/%b exp=1/0", fault_a, valid_a); end
      checks++; if (seen1) begin errors++; $display("FAIL fault_noreq got=offset1 exp=none"); end
   endtask

   task automatic test_reset_mid_wait();
      int e;
      do_reset();
      len_a = 3; en_a = 1;
      wait_valid_a(20, e);
      ack_a_pulse(0, 0, 0);
      @(negedge clk);
      #2 reset = 0;
      #1;
      checks++; if (pc_a !== 32'd0 || valid_a !== 1'b0 || word_a !== 32'd0) begin errors++; $display("FAIL midwait_reset got pc=%0d v=%b w=%h exp=0/0/0", pc_a, valid_a, word_a); end
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      checks++; if (min_a.offset !== 32'd0) begin errors++; $display("FAIL midwait_refetch_off got=%0d exp=0", min_a.offset); end
      wait_valid_a(20, e);
      checks++; if (word_a !== mem[0] || pc_a !== 32'd1) begin errors++; $display("FAIL midwait_refetch got=%h pc=%0d exp=%h pc=1", word_a, pc_a, mem[0]); end
   endtask

   task automatic test_enable_gap();
      int e;
      bit bad;
      do_reset();
      len_a = 3; en_a = 1;
      @(negedge clk);
      en_a = 0;
      wait_valid_a(20, e);
      checks++; if (valid_a !== 1'b1 || word_a !== mem[0]) begin errors++; $display("FAIL engap_word got=%b/%h exp=1/%h", valid_a, word_a, mem[0]); end
      ack_a_pulse(0, 0, 0);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (valid_a !== 1'b0 || min_a.offset !== 32'd0 || pc_a !== 32'd1) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL engap_idle got=activity exp=none"); end
      en_a = 1;
      @(negedge clk);
      wait_valid_a(20, e);
      checks++; if (e !== 2) begin errors++; $display("FAIL engap_latency got=%0d exp=2", e); end
      checks++; if (word_a !== mem[1]) begin errors++; $display("FAIL engap_resume got=%h exp=%h", word_a, mem[1]); end
   endtask

   task automatic test_lat3();
      int e;
      bit offbad;
      do_reset();
      len_b = 3; en_b = 1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e = 0; offbad = 0;
         while (valid_b !== 1'b1 && e < 20) begin
            @(negedge clk);
            e++;
            if (valid_b !== 1'b1 && e > 1 && min_b.offset !== k) offbad = 1;
         end
         checks++; if (e !== 4) begin errors++; $display("FAIL lat3_latency%0d got=%0d exp=4", k, e); end
         checks++; if (word_b !== mem[k] || pc_b !== k + 1) begin errors++; $display("FAIL lat3_word%0d got=%h pc=%0d exp=%h pc=%0d", k, word_b, pc_b, mem[k], k + 1); end
         checks++; if (offbad) begin errors++; $display("FAIL lat3_offset_hold%0d got=moved exp=%0d", k, k); end
         ack_b = 1;
         @(negedge clk);
         ack_b = 0;
      end
   endtask

   task automatic test_boundary();
      int e;
      do_reset();
      len_a = 32'hFFFFFFFF; en_a = 1;
      wait_valid_a(20, e);
      ack_a_pulse(1, 32'hFFFFFFFE, 0);
      wait_valid_a(20, e);
      checks++; if (word_a !== mem[14] || pc_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL top_word got=%h pc=%h exp=%h pc=ffffffff", word_a, pc_a, mem[14]); end
      ack_a_pulse(0, 0, 0);
      repeat (3) @(negedge clk);
      checks++; if (fault_a !== 1'b1 || pc_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL top_fault got=%b pc=%h exp=1 pc=ffffffff", fault_a, pc_a); end
      do_reset();
      len_a = 3;
      ack_a = 1; hlt_a = 1; en_a = 1;
      @(negedge clk);
      @(negedge clk);
      ack_a = 0; hlt_a = 0;
      @(negedge clk);
      checks++; if (valid_a !== 1'b1 || halted_a !== 1'b0) begin errors++; $display("FAIL early_ack got v=%b h=%b exp=1/0", valid_a, halted_a); end
   endtask

   task automatic test_random();
      int e, hold;
      logic [31:0] pc_m, len, tgt;
      logic [31:0] w;
      logic j;
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      len = $urandom_range(4, 16);
      len_a = len; en_a = 1;
      pc_m = 0;
      @(negedge clk);
      for (int n = 0; n < 40; n++) begin
         if (pc_m >= len) begin
            repeat (3) @(negedge clk);
            checks++; if (fault_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL rnd_fault got=%b/%b exp=1/0 pc=%0d len=%0d", fault_a, valid_a, pc_m, len); end
            break;
         end
         wait_valid_a(20, e);
         checks++; if (e !== 2) begin errors++; $display("FAIL rnd_latency got=%0d exp=2", e); end
         checks++; if (word_a !== mem[pc_m[3:0]] || pc_a !== pc_m + 1) begin errors++; $display("FAIL rnd_word got=%h pc=%0d exp=%h pc=%0d", word_a, pc_a, mem[pc_m[3:0]], pc_m + 1); end
         w = word_a;
         hold = $urandom_range(0, 3);
         repeat (hold) @(negedge clk);
         checks++; if (valid_a !== 1'b1 || word_a !== w) begin errors++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", valid_a, word_a, w); end
         j = ($urandom_range(0, 2) == 0);
         tgt = $urandom_range(0, len);
         if ($urandom_range(0, 19) == 0) begin
            ack_a_pulse(j, tgt, 1);
            checks++; if (halted_a !== 1'b1 || pc_a !== pc_m + 1) begin errors++; $display("FAIL rnd_halt got=%b pc=%0d exp=1 pc=%0d", halted_a, pc_a, pc_m + 1); end
            break;
         end
         ack_a_pulse(j, tgt, 0);
         pc_m = j ? tgt : pc_m + 1;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[0] = 32'h30000053; mem[1] = 32'h40000053; mem[2] = 32'h70000000;
      test_reset();
      test_program();
      test_jump();
      test_halt();
      test_fault();
      test_reset_mid_wait();
      test_enable_gap();
      test_lat3();
      test_boundary();
      test_random();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
